// File: rtl/hs_arb_pkg.sv
// Shared types and constants for the hiscore/CPU work-RAM arbiter.
package hs_arb_pkg;

    typedef enum logic [2:0] {
        CPU,
        DRAIN,
        SETTLE_IN,
        HS,
        SETTLE_OUT
    } arb_state_t;

    localparam int SETTLE_W  = $clog2(16);
    localparam int HS_ARB_AW = 12;
    localparam int HS_ARB_DW = 8;

endpackage

// File: rtl/hs_arb_mux.sv
// Work-RAM port selector: routes CPU or hiscore address/data/strobe by arbiter state.
module hs_arb_mux
    import hs_arb_pkg::*;
#(
    parameter int AW = HS_ARB_AW,
    parameter int DW = HS_ARB_DW
) (
    input  arb_state_t       state_i,
    input  logic             cpu_cen_i,
    input  logic             cpu_cs_i,
    input  logic             cpu_we_i,
    input  logic [AW-1:0]    cpu_addr_i,
    input  logic [DW-1:0]    cpu_dout_i,
    input  logic [AW-1:0]    hs_address_i,
    input  logic [DW-1:0]    hs_data_in_i,
    input  logic             hs_write_enable_i,
    output logic [AW-1:0]    ram_addr_o,
    output logic [DW-1:0]    ram_din_o,
    output logic             ram_we_o
);

    always_comb begin
        ram_addr_o = cpu_addr_i;
        ram_din_o  = cpu_dout_i;
        ram_we_o   = 1'b0;
        unique case (state_i)
            // DRAIN still belongs to the CPU so its final bus cycle completes.
            CPU, DRAIN: ram_we_o = cpu_cs_i & cpu_we_i & cpu_cen_i;
            HS: begin
                ram_addr_o = hs_address_i;
                ram_din_o  = hs_data_in_i;
                ram_we_o   = hs_write_enable_i;
            end
            default: ram_we_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/hs_ram_arbiter.sv
// Arbitrates the work-RAM port between the CPU and the hiscore engine.
// Optional `HS_ARB_TIMEOUT_EN forces the grant if no CPU bus boundary arrives.
module hs_ram_arbiter
    import hs_arb_pkg::*;
#(
    parameter int AW      = HS_ARB_AW,
    parameter int DW      = HS_ARB_DW,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk_49m,
    input  logic             reset,
    input  logic             cpu_cen,
    input  logic             cpu_cs,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [DW-1:0]    cpu_dout,
    output logic [DW-1:0]    cpu_din,
    output logic             cpu_hold,
    input  logic             hs_req,
    input  logic [AW-1:0]    hs_address,
    input  logic [DW-1:0]    hs_data_in,
    input  logic             hs_write_enable,
    output logic             hs_grant,
    output logic [DW-1:0]    hs_data_out,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_din,
    output logic             ram_we,
`ifdef HS_ARB_TIMEOUT_EN
    output logic             hs_timeout,
`endif
    input  logic [DW-1:0]    ram_dout
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

    arb_state_t          state_q, state_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic                settle_done;
    logic                tmo_hit;

    assign settle_done = (cnt_q == SETTLE_LAST);

`ifdef HS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          hs_timeout_q, hs_timeout_d;

    assign tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));
    assign hs_timeout = hs_timeout_q;

    always_comb begin
        tmo_d        = '0;
        hs_timeout_d = hs_timeout_q;
        if (state_q == DRAIN) begin
            tmo_d = tmo_q + 1'b1;
            if (hs_req && !cpu_cen && tmo_hit) hs_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            tmo_q        <= '0;
            hs_timeout_q <= 1'b0;
        end else begin
            tmo_q        <= tmo_d;
            hs_timeout_q <= hs_timeout_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            state_q <= CPU;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            CPU:   if (hs_req) state_d = DRAIN;
            // Losing the request before the grant still takes the SETTLE_OUT path.
            DRAIN: begin
                if (!hs_req)                 state_d = SETTLE_OUT;
                else if (cpu_cen || tmo_hit) state_d = SETTLE_IN;
            end
            SETTLE_IN: begin
                if (!hs_req)          state_d = SETTLE_OUT;
                else if (settle_done) state_d = HS;
                else                  cnt_d   = cnt_q + 1'b1;
            end
            HS:    if (!hs_req) state_d = SETTLE_OUT;
            SETTLE_OUT: begin
                if (settle_done) state_d = CPU;
                else             cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = CPU;
        endcase
    end

    assign cpu_hold    = (state_q == SETTLE_IN) || (state_q == HS) || (state_q == SETTLE_OUT);
    assign hs_grant    = (state_q == HS);
    assign cpu_din     = ram_dout;
    assign hs_data_out = hs_grant ? ram_dout : '0;

    hs_arb_mux #(
        .AW (AW),
        .DW (DW)
    ) u_mux (
        .state_i           (state_q),
        .cpu_cen_i         (cpu_cen),
        .cpu_cs_i          (cpu_cs),
        .cpu_we_i          (cpu_we),
        .cpu_addr_i        (cpu_addr),
        .cpu_dout_i        (cpu_dout),
        .hs_address_i      (hs_address),
        .hs_data_in_i      (hs_data_in),
        .hs_write_enable_i (hs_write_enable),
        .ram_addr_o        (ram_addr),
        .ram_din_o         (ram_din),
        .ram_we_o          (ram_we)
    );

endmodule
